// File: rtl/vga_scanout.sv
// vga_scanout: VGA raster timing plus per-pixel RGB332 fetch over the shared {x,y} video bus.
// Latency: fetch address is combinational from the counters; rgb and syncs appear one clk later.
// Backpressure: none; the dma may use the bus only while vga_blank is high.
module vga_scanout #(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter int   PIX_SHIFT = 1,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  y_scroll,
    inout  wire  [16:0] op_addr,
    inout  wire  [7:0]  op_data,
    inout  wire         op_re,
    output logic        vga_blank,
    output logic        hsync,
    output logic        vsync,
    output logic [2:0]  r,
    output logic [2:0]  g,
    output logic [1:0]  b,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [7:0]    y_lat_q, y_lat_d;
    logic [7:0]    rgb_q, rgb_d;
    logic          vga_blank_q, vga_blank_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          frame_start_q, frame_start_d;
    logic [8:0]    fetch_x;
    logic [7:0]    fetch_y;

    always_comb begin
        h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
        end
        frame_start_d = (h_cnt_d == '0) && (v_cnt_d == '0);
        // Scroll offset is latched entering the first pixel so a whole frame uses one value.
        y_lat_d       = frame_start_d ? y_scroll : y_lat_q;
        vga_blank_d   = !((h_cnt_d < H_ACT) && (v_cnt_d < V_ACT));
        hsync_d       = (h_cnt_q >= HS_BEG && h_cnt_q < HS_END) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = (v_cnt_q >= VS_BEG && v_cnt_q < VS_END) ? SYNC_POL : ~SYNC_POL;
        rgb_d         = vga_blank_q ? 8'h00 : op_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= H_LAST;
            v_cnt_q       <= V_LAST;
            y_lat_q       <= 8'h00;
            rgb_q         <= 8'h00;
            vga_blank_q   <= 1'b1;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            y_lat_q       <= y_lat_d;
            rgb_q         <= rgb_d;
            vga_blank_q   <= vga_blank_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign fetch_x = 9'(h_cnt_q >> PIX_SHIFT);
    assign fetch_y = 8'(v_cnt_q >> PIX_SHIFT) + y_lat_q;

    // Bus ownership follows the registered blank flag, so release coincides with vga_blank rising.
    assign op_addr = vga_blank_q ? 17'bz : {fetch_x, fetch_y};
    assign op_re   = vga_blank_q ? 1'bz  : 1'b1;

    assign vga_blank   = vga_blank_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign r           = rgb_q[7:5];
    assign g           = rgb_q[4:2];
    assign b           = rgb_q[1:0];
    assign frame_start = frame_start_q;
endmodule
